// File: rtl/ifq_pkg.sv
// Shared types and default sizing for the instruction fetch queue.
// Entry layout is fixed here so fetch, queue and decode agree on it.
package ifq_pkg;

    localparam int IFQ_DEPTH   = 16;
    localparam int IFQ_FETCH_W = 2;
    localparam int IFQ_DISP_W  = 2;
    localparam int IFQ_PC_W    = 64;

    typedef struct packed {
        logic [31:0]         insn;
        logic [IFQ_PC_W-1:0] pc;
        logic [IFQ_PC_W-1:0] target_pc;
        logic                pred_bit;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_prefix_cnt.sv
// Counts the run of set bits starting at bit 0; anything above the first
// clear bit is ignored, so a hole in the fetch lanes truncates the group.
module ifq_prefix_cnt #(
    parameter int W     = 2,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scanning downward leaves the lowest clear bit's index as the result.
    always_comb begin
        cnt_o = CNT_W'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (!bits_i[i]) begin
                cnt_o = CNT_W'(i);
            end
        end
    end

endmodule

// File: rtl/ifq_ss.sv
// Superscalar instruction fetch queue: circular buffer with multi-lane
// enqueue from fetch and multi-lane, age-ordered dequeue to decode.
module ifq_ss
    import ifq_pkg::*;
#(
    parameter int DEPTH   = IFQ_DEPTH,
    parameter int FETCH_W = IFQ_FETCH_W,
    parameter int DISP_W  = IFQ_DISP_W,
    parameter int PC_W    = IFQ_PC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic [FETCH_W-1:0]            enq_valid_i,
    input  ifq_entry_t [FETCH_W-1:0]      enq_entry_i,
    output logic                          enq_ready_o,
    output logic [DISP_W-1:0]             deq_valid_o,
    output ifq_entry_t [DISP_W-1:0]       deq_entry_o,
    input  logic [$clog2(DISP_W+1)-1:0]   deq_cnt_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENQ_W   = $clog2(FETCH_W + 1);
    localparam int ENTRY_W = 33 + 2 * PC_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   deq_clip;
    logic [ENQ_W-1:0]   enq_n;
    logic [ENQ_W-1:0]   enq_acc;

    ifq_prefix_cnt #(
        .W     (FETCH_W),
        .CNT_W (ENQ_W)
    ) u_prefix_cnt (
        .bits_i (enq_valid_i),
        .cnt_o  (enq_n)
    );

    // Ready depends only on registered occupancy: a full fetch group must
    // fit without counting on this cycle's dequeue.
    assign enq_ready_o = (count_q <= CNT_W'(DEPTH - FETCH_W));
    assign enq_acc     = enq_ready_o ? enq_n : '0;

    always_comb begin
        deq_clip = CNT_W'(deq_cnt_i);
        if (deq_clip > CNT_W'(DISP_W)) begin
            deq_clip = CNT_W'(DISP_W);
        end
        if (deq_clip > count_q) begin
            deq_clip = count_q;
        end
        head_d  = head_q + PTR_W'(deq_clip);
        tail_d  = tail_q + PTR_W'(enq_acc);
        count_d = count_q + CNT_W'(enq_acc) - deq_clip;
    end

    // Flush only rewinds the pointers; storage keeps its stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < FETCH_W; i++) begin
                if (ENQ_W'(i) < enq_acc) begin
                    mem_q[tail_q + PTR_W'(i)] <= enq_entry_i[i];
                end
            end
        end
    end

    always_comb begin
        deq_valid_o = '0;
        deq_entry_o = '0;
        for (int i = 0; i < DISP_W; i++) begin
            deq_valid_o[i] = (CNT_W'(i) < count_q);
            deq_entry_o[i] = ifq_entry_t'(mem_q[head_q + PTR_W'(i)]);
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_ifq_ss.sv
// Randomised bench for ifq_ss: a queue-based model predicts every output,
// plus directed scenarios with hand-computed expectations.
module tb_ifq_ss;
    import ifq_pkg::*;

    localparam int DEPTH   = 16;
    localparam int FETCH_W = 2;
    localparam int DISP_W  = 2;

    logic                   clk;
    logic                   rst;
    logic                   flushIn;
    logic [FETCH_W-1:0]     enqValid;
    ifq_entry_t [FETCH_W-1:0] enqEntry;
    logic                   enqReady;
    logic [DISP_W-1:0]      deqValid;
    ifq_entry_t [DISP_W-1:0]  deqEntry;
    logic [1:0]             deqCnt;
    logic [4:0]             countOut;
    logic                   emptyOut;
    logic                   fullOut;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 0;

    ifq_entry_t modelQ[$];

    ifq_ss #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .DISP_W  (DISP_W),
        .PC_W    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flushIn),
        .enq_valid_i (enqValid),
        .enq_entry_i (enqEntry),
        .enq_ready_o (enqReady),
        .deq_valid_o (deqValid),
        .deq_entry_o (deqEntry),
        .deq_cnt_i   (deqCnt),
        .count_o     (countOut),
        .empty_o     (emptyOut),
        .full_o      (fullOut)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ifq_entry_t makeEntry(input logic [63:0] pc);
        ifq_entry_t e;
        e.insn      = $urandom;
        e.pc        = pc;
        e.target_pc = {$urandom, $urandom};
        e.pred_bit  = 1'($urandom);
        return e;
    endfunction

    task automatic applyStimulus(input logic f, input logic [1:0] v,
                                 input logic [63:0] pc0, input logic [63:0] pc1,
                                 input logic [1:0] dc);
        flushIn     = f;
        enqValid    = v;
        enqEntry[0] = makeEntry(pc0);
        enqEntry[1] = makeEntry(pc1);
        deqCnt      = dc;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain FIFO of entries updated on each rising edge.
    always @(posedge clk) begin
        int n;
        int cnt;
        int dc;
        if (rst || flushIn) begin
            modelQ.delete();
        end else begin
            cnt = modelQ.size();
            n = 0;
            while (n < FETCH_W && enqValid[n]) n++;
            dc = int'(deqCnt);
            if (dc > cnt) dc = cnt;
            if (dc > DISP_W) dc = DISP_W;
            repeat (dc) void'(modelQ.pop_front());
            if (DEPTH - cnt >= FETCH_W) begin
                for (int i = 0; i < n; i++) modelQ.push_back(enqEntry[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("count_o", 256'(countOut), 256'(modelQ.size()));
            checkOutput("empty_o", 256'(emptyOut), 256'(modelQ.size() == 0));
            checkOutput("full_o", 256'(fullOut), 256'(modelQ.size() == DEPTH));
            checkOutput("enq_ready_o", 256'(enqReady), 256'(DEPTH - modelQ.size() >= FETCH_W));
            for (int i = 0; i < DISP_W; i++) begin
                checkOutput("deq_valid_o", 256'(deqValid[i]), 256'(i < modelQ.size()));
                if (i < modelQ.size()) begin
                    checkOutput("deq_entry_o", 256'(deqEntry[i]), 256'(modelQ[i]));
                end
            end
        end
    end

    initial begin
        logic [63:0] nextPc;
        logic [63:0] expectPc;
        logic [1:0]  v;
        logic [1:0]  dc;
        logic        f;
        bit          fillPhase;

        rst      = 1;
        flushIn  = 0;
        enqValid = '0;
        enqEntry = '0;
        deqCnt   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 0;
        checkEn = 1;

        checkOutput("reset count", 256'(countOut), 256'(0));
        checkOutput("reset empty", 256'(emptyOut), 256'(1));
        checkOutput("reset full", 256'(fullOut), 256'(0));
        checkOutput("reset ready", 256'(enqReady), 256'(1));
        checkOutput("reset valid", 256'(deqValid), 256'(0));
        checkOutput("reset entry0", 256'(deqEntry[0]), 256'(0));
        checkOutput("reset entry1", 256'(deqEntry[1]), 256'(0));

        applyStimulus(0, 2'b11, 64'h100, 64'h104, 2'd0);
        checkOutput("first count", 256'(countOut), 256'(2));
        checkOutput("first valid", 256'(deqValid), 256'(2'b11));
        checkOutput("first pc0", 256'(deqEntry[0].pc), 256'(64'h100));
        checkOutput("first pc1", 256'(deqEntry[1].pc), 256'(64'h104));

        applyStimulus(0, 2'b10, 64'h200, 64'h204, 2'd0);
        checkOutput("hole lane count", 256'(countOut), 256'(2));

        nextPc = 64'h108;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 2'b11, nextPc, nextPc + 64'd4, 2'd0);
            nextPc += 64'd8;
        end
        applyStimulus(0, 2'b01, nextPc, nextPc + 64'd4, 2'd0);
        checkOutput("fill15 count", 256'(countOut), 256'(15));
        checkOutput("fill15 ready", 256'(enqReady), 256'(0));
        applyStimulus(0, 2'b11, 64'hdead0, 64'hdead4, 2'd1);
        checkOutput("drop count", 256'(countOut), 256'(14));
        checkOutput("drop ready", 256'(enqReady), 256'(1));

        for (int k = 0; k < 6; k++) applyStimulus(0, 2'b00, 64'h0, 64'h0, 2'd2);
        applyStimulus(0, 2'b00, 64'h0, 64'h0, 2'd1);
        checkOutput("drain count", 256'(countOut), 256'(1));
        applyStimulus(0, 2'b11, 64'h300, 64'h304, 2'd2);
        checkOutput("clip count", 256'(countOut), 256'(2));
        checkOutput("clip head pc", 256'(deqEntry[0].pc), 256'(64'h300));

        expectPc = 64'h300;
        nextPc   = 64'h308;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 2'b11, nextPc, nextPc + 64'd4, 2'd2);
            nextPc   += 64'd8;
            expectPc += 64'd8;
            checkOutput("stream count", 256'(countOut), 256'(2));
            checkOutput("stream pc0", 256'(deqEntry[0].pc), 256'(expectPc));
            checkOutput("stream pc1", 256'(deqEntry[1].pc), 256'(expectPc + 64'd4));
        end

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 2'b11, nextPc, nextPc + 64'd4, 2'd0);
            nextPc += 64'd8;
        end
        applyStimulus(0, 2'b01, nextPc, nextPc + 64'd4, 2'd0);
        checkOutput("pre-flush count", 256'(countOut), 256'(9));
        applyStimulus(1, 2'b11, 64'h500, 64'h504, 2'd2);
        checkOutput("flush count", 256'(countOut), 256'(0));
        checkOutput("flush empty", 256'(emptyOut), 256'(1));
        checkOutput("flush valid", 256'(deqValid), 256'(0));

        fillPhase = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) fillPhase = ~fillPhase;
            v  = (($urandom % 10) < 6) ? 2'b11 : 2'($urandom);
            if (!fillPhase) v = (($urandom % 3) == 0) ? 2'($urandom) : 2'b00;
            dc = 2'($urandom);
            if (fillPhase && ($urandom % 2 == 0)) dc = 2'd0;
            f  = (($urandom % 100) < 3);
            if (($urandom % 200) == 0) rst = 1;
            applyStimulus(f, v, {$urandom, $urandom}, {$urandom, $urandom}, dc);
            rst = 0;
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ifq_ss.md
IFQ_SS -- requirements
Module: ifq_ss

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of 2, DEPTH >= 2*FETCH_W).
REQ-002 SHALL have parameter FETCH_W, default 2, enqueue lanes per cycle.
REQ-003 SHALL have parameter DISP_W, default 2, dequeue lanes per cycle.
REQ-004 SHALL have parameter PC_W, default 64, PC and target-PC width.
REQ-005 SHALL have port clk  in  1  clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush_i  in  1  branch-mispredict flush.
REQ-008 SHALL have port enq_valid_i  in  FETCH_W  per-lane fetch valid.
REQ-009 SHALL have port enq_entry_i  in  FETCH_W x ifq_entry_t  per-lane {insn[31:0], pc, target_pc, pred_bit}.
REQ-010 SHALL have port enq_ready_o  out  1  queue can accept FETCH_W entries.
REQ-011 SHALL have port deq_valid_o  out  DISP_W  lane i holds the i-th oldest entry.
REQ-012 SHALL have port deq_entry_o  out  DISP_W x ifq_entry_t  oldest entries, in age order.
REQ-013 SHALL have port deq_cnt_i  in  clog2(DISP_W+1)  entries consumed by decode this cycle.
REQ-014 SHALL have port count_o  out  clog2(DEPTH+1)  occupied entries.
REQ-015 SHALL have ports empty_o and full_o  out  1 each  count_o==0, count_o==DEPTH.

Function
REQ-016 SHALL define enq_n as the number of contiguous set bits of enq_valid_i starting at lane 0; lanes above the first clear bit are ignored.
REQ-017 SHALL assert enq_ready_o combinationally iff DEPTH - count_o >= FETCH_W, using registered count only; no same-cycle credit from dequeue.
REQ-018 SHALL write lane i to slot (tail+i) mod DEPTH for i < enq_n, and advance tail by enq_n, only when enq_ready_o=1; otherwise drop all lanes and leave state unchanged.
REQ-019 SHALL drive deq_valid_o[i] = (i < count_o) and deq_entry_o[i] = slot (head+i) mod DEPTH, as pure functions of registered state (no enqueue-to-dequeue bypass; minimum latency 1 cycle).
REQ-020 SHALL clip deq_cnt_i to min(deq_cnt_i, count_o, DISP_W) and advance head by the clipped value.
REQ-021 SHALL update count_next = count + enq_accepted - deq_clipped when enqueue and dequeue occur in the same cycle.
REQ-022 SHALL wrap head and tail modulo DEPTH with no bubble slots; all DEPTH entries usable.
REQ-023 SHALL, on flush_i=1, set head, tail and count to 0 next cycle, ignoring that cycle's enqueue and dequeue; entry storage not cleared.
REQ-024 SHALL give flush_i priority over enqueue and dequeue, and rst priority over flush_i.
REQ-025 SHALL drive deq_entry_o lanes with deq_valid_o=0 from stale storage; consumers ignore them.

Reset
REQ-026 SHALL on rst clear head, tail, count and all storage to 0 at the next rising edge.
REQ-027 SHALL after reset output deq_valid_o=0, deq_entry_o=0, count_o=0, empty_o=1, full_o=0, enq_ready_o=1.
REQ-028 SHALL abandon any in-flight enqueue or dequeue when rst is asserted mid-operation.

Structure
REQ-029 SHALL place ifq_entry_t and the default DEPTH/FETCH_W/DISP_W values in shared package ifq_pkg.
REQ-030 SHALL implement the contiguous-prefix count (REQ-016) in sub-module ifq_prefix_cnt, parametrised by width.

Verification
REQ-031 SHALL cover: after reset, enq_valid_i=2'b11 with PCs 0x100, 0x104 -> next cycle count_o=2, deq_valid_o=2'b11, deq_entry_o[0].pc=0x100.
REQ-032 SHALL cover: enq_valid_i=2'b10 -> nothing written, count_o unchanged.
REQ-033 SHALL cover: fill to count_o=15 (DEPTH=16) -> enq_ready_o=0; enq_valid_i=2'b11 dropped; deq_cnt_i=1 -> count_o=14, enq_ready_o=1.
REQ-034 SHALL cover: count_o=1, deq_cnt_i=2 with enq_valid_i=2'b11 -> count_o=2, head advanced by 1 only.
REQ-035 SHALL cover: 40 cycles of simultaneous 2-in/2-out traffic -> head and tail wrap at 16, output PC order strictly sequential, count_o constant.
REQ-036 SHALL cover: flush_i with count_o=9 plus concurrent enqueue -> next cycle count_o=0, empty_o=1, deq_valid_o=0.
